// File: rtl/pipelined_ctrl_decoder_if.sv
// Bundle of every non-clock/reset signal of pipelined_ctrl_decoder.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid & ready are both high. A producer holding valid keeps its payload
// stable until that edge. The decoder's in_ready does not depend on in_valid.
//
// master : fetch/execute/mult-div side (drives insn, out_ready, md_ready...)
// slave  : the decoder itself
//
// Signals
//   flush, in_valid, in_ready, insn        fetch side
//   out_valid, out_ready + decoded fields  execute side
//   md_start, md_is_div, md_ready, md_error, md_exc   mult/div sequencing
//   dbg_state                               decoder FSM state (0=IDLE, 1=MD_WAIT, 2=DRAIN)
interface pipelined_ctrl_decoder_if #(
  parameter int INSN_W  = 32,
  parameter int ALUOP_W = 5,
  parameter int SHAMT_W = 5,
  parameter int REG_W   = 5
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSN_W-1:0]  insn;
  logic               out_valid;
  logic               out_ready;
  logic               Rwe;
  logic               Rs2;
  logic               ALUinB;
  logic               DMwe;
  logic               Rwd;
  logic [ALUOP_W-1:0] ALUop;
  logic [SHAMT_W-1:0] shiftamt;
  logic [REG_W-1:0]   rd;
  logic [REG_W-1:0]   rs;
  logic [REG_W-1:0]   rt;
  logic [INSN_W-1:0]  imm;
  logic               is_muldiv;
  logic               illegal;
  logic               md_start;
  logic               md_is_div;
  logic               md_ready;
  logic               md_error;
  logic               md_exc;
  logic [1:0]         dbg_state;

  modport master (
    output flush, in_valid, insn, out_ready, md_ready, md_error,
    input  in_ready, out_valid, Rwe, Rs2, ALUinB, DMwe, Rwd, ALUop, shiftamt,
           rd, rs, rt, imm, is_muldiv, illegal, md_start, md_is_div, md_exc,
           dbg_state
  );

  modport slave (
    input  flush, in_valid, insn, out_ready, md_ready, md_error,
    output in_ready, out_valid, Rwe, Rs2, ALUinB, DMwe, Rwd, ALUop, shiftamt,
           rd, rs, rt, imm, is_muldiv, illegal, md_start, md_is_div, md_exc,
           dbg_state
  );
endinterface

// File: rtl/pipelined_ctrl_decoder.sv
// pipelined_ctrl_decoder
// Registered control decoder between fetch and execute. One decoded bundle is
// held in the output stage under valid/ready. Mult/div instructions are loaded
// into the output stage but only become valid after the mult/div unit answers
// (md_ready) or a timeout of MD_TIMEOUT cycles expires (md_exc forced to 1).
// Unknown encodings produce a bundle with illegal=1 and all control bits zero.
//
// Ports
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; returns every output and the FSM to 0/IDLE
//   bus    : pipelined_ctrl_decoder_if.slave (handshakes, decoded fields,
//            mult/div start/ready exchange, dbg_state)
//
// Interface parameters must match this module's width parameters.
module pipelined_ctrl_decoder #(
  parameter int INSN_W     = 32,
  parameter int ALUOP_W    = 5,
  parameter int SHAMT_W    = 5,
  parameter int REG_W      = 5,
  parameter int IMM_W      = 17,
  parameter int MD_TIMEOUT = 64
) (
  input logic                    clock,
  input logic                    reset,
  pipelined_ctrl_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   md_cnt;

  // Output-stage registers
  logic               out_valid_q;
  logic               rwe_q, rs2_q, aluinb_q, dmwe_q, rwd_q;
  logic [ALUOP_W-1:0] aluop_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [REG_W-1:0]   rd_q, rs_q, rt_q;
  logic [INSN_W-1:0]  imm_q;
  logic               is_muldiv_q, illegal_q;
  logic               md_start_q, md_is_div_q, md_exc_q;

  // Combinational decode of the presented instruction
  logic [4:0]         opcode;
  logic [ALUOP_W-1:0] r_aluop;
  logic [SHAMT_W-1:0] r_shamt;
  logic               d_rwe, d_rs2, d_aluinb, d_dmwe, d_rwd;
  logic [ALUOP_W-1:0] d_aluop;
  logic [SHAMT_W-1:0] d_shamt;
  logic               d_md, d_ill, d_is_div;
  logic               accept;

  assign opcode  = bus.insn[INSN_W-1 -: 5];
  assign r_aluop = bus.insn[2 +: ALUOP_W];
  assign r_shamt = bus.insn[7 +: SHAMT_W];

  always_comb begin
    d_rwe    = 1'b0;
    d_rs2    = 1'b0;
    d_aluinb = 1'b0;
    d_dmwe   = 1'b0;
    d_rwd    = 1'b0;
    d_aluop  = '0;
    d_shamt  = '0;
    d_md     = 1'b0;
    d_ill    = 1'b0;
    case (opcode)
      5'b00000: begin
        if (r_aluop <= ALUOP_W'(5)) begin
          d_rwe   = 1'b1;
          d_aluop = r_aluop;
          d_shamt = r_shamt;
        end else if (r_aluop == ALUOP_W'(6) || r_aluop == ALUOP_W'(7)) begin
          d_rwe   = 1'b1;
          d_aluop = r_aluop;
          d_shamt = r_shamt;
          d_md    = 1'b1;
        end else begin
          // Illegal R-type: everything stays zero so nothing is written.
          d_ill = 1'b1;
        end
      end
      5'b00101: begin  // addi
        d_rwe    = 1'b1;
        d_aluinb = 1'b1;
      end
      5'b00111: begin  // sw
        d_rs2    = 1'b1;
        d_aluinb = 1'b1;
        d_dmwe   = 1'b1;
      end
      5'b01000: begin  // lw
        d_rwe    = 1'b1;
        d_aluinb = 1'b1;
        d_rwd    = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end

  assign d_is_div = (r_aluop == ALUOP_W'(7));

  // Only IDLE accepts; flush and reset block acceptance in the same cycle.
  assign bus.in_ready = (state == IDLE) & (~out_valid_q | bus.out_ready) &
                        ~bus.flush & ~reset;
  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      md_cnt      <= '0;
      out_valid_q <= 1'b0;
      rwe_q       <= 1'b0;
      rs2_q       <= 1'b0;
      aluinb_q    <= 1'b0;
      dmwe_q      <= 1'b0;
      rwd_q       <= 1'b0;
      aluop_q     <= '0;
      shamt_q     <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      is_muldiv_q <= 1'b0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_is_div_q <= 1'b0;
      md_exc_q    <= 1'b0;
    end else if (bus.flush) begin
      // Kill whatever is held or in flight; a pending mult/div answer is
      // ignored because MD_WAIT is left here.
      state       <= IDLE;
      md_cnt      <= '0;
      out_valid_q <= 1'b0;
      md_exc_q    <= 1'b0;
      md_start_q  <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            rwe_q       <= d_rwe;
            rs2_q       <= d_rs2;
            aluinb_q    <= d_aluinb;
            dmwe_q      <= d_dmwe;
            rwd_q       <= d_rwd;
            aluop_q     <= d_aluop;
            shamt_q     <= d_shamt;
            rd_q        <= bus.insn[22 +: REG_W];
            rs_q        <= bus.insn[17 +: REG_W];
            rt_q        <= bus.insn[12 +: REG_W];
            imm_q       <= {{(INSN_W-IMM_W){bus.insn[IMM_W-1]}}, bus.insn[IMM_W-1:0]};
            is_muldiv_q <= d_md;
            illegal_q   <= d_ill;
            md_exc_q    <= 1'b0;
            if (d_md) begin
              // Fields are loaded now but stay invisible until the result.
              out_valid_q <= 1'b0;
              md_start_q  <= 1'b1;
              md_is_div_q <= d_is_div;
              md_cnt      <= '0;
              state       <= MD_WAIT;
            end else begin
              out_valid_q <= 1'b1;
            end
          end
        end
        MD_WAIT: begin
          if (bus.md_ready) begin
            out_valid_q <= 1'b1;
            md_exc_q    <= bus.md_error;
            md_cnt      <= '0;
            state       <= DRAIN;
          end else if (md_cnt == CNT_LAST) begin
            out_valid_q <= 1'b1;
            md_exc_q    <= 1'b1;
            md_cnt      <= '0;
            state       <= DRAIN;
          end else begin
            md_cnt <= md_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Rwe       = rwe_q;
  assign bus.Rs2       = rs2_q;
  assign bus.ALUinB    = aluinb_q;
  assign bus.DMwe      = dmwe_q;
  assign bus.Rwd       = rwd_q;
  assign bus.ALUop     = aluop_q;
  assign bus.shiftamt  = shamt_q;
  assign bus.rd        = rd_q;
  assign bus.rs        = rs_q;
  assign bus.rt        = rt_q;
  assign bus.imm       = imm_q;
  assign bus.is_muldiv = is_muldiv_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_start  = md_start_q;
  assign bus.md_is_div = md_is_div_q;
  assign bus.md_exc    = md_exc_q;
  assign bus.dbg_state = state;

endmodule
